// File: rtl/stack_transfer_sequencer_pkg.sv
// Shared types and constants for the PUSH/POP register-list sequencer.
// Register indices follow this codebase's bank numbering.
package stack_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_WB     = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  // Which register-bank port the sequencer is exercising this cycle.
  typedef enum logic [1:0] {
    BANK_NONE  = 2'd0,
    BANK_READ  = 2'd1,
    BANK_WRITE = 2'd2,
    BANK_PC    = 2'd3
  } bank_op_e;

  localparam int LR_INDEX_DEF = 13;
  localparam int SP_INDEX_DEF = 14;
  localparam int PC_INDEX_DEF = 15;

endpackage

// File: rtl/reglist_priority_encoder.sv
// Lowest-set-bit encoder for the remaining register mask.
module reglist_priority_encoder
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [IDX_W-1:0] index_o,
  output logic             valid_o
);

  // Scanning downwards lets the lowest set bit win.
  always_comb begin
    index_o = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        index_o = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_transfer_sequencer.sv
// Walks a PUSH/POP register list one word at a time, driving memory,
// the register bank, the PC load and the final SP update.
module stack_transfer_sequencer
  import stack_seq_pkg::*;
#(
  parameter int REGISTER_LENGTH = 32,
  parameter int LIST_WIDTH      = 8,
  parameter int LR_INDEX        = LR_INDEX_DEF,
  parameter int PC_INDEX        = PC_INDEX_DEF
) (
  input  logic                       fast_clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       is_pop,
  input  logic [LIST_WIDTH-1:0]      reg_list,
  input  logic                       extra_bit,
  input  logic [REGISTER_LENGTH-1:0] sp_in,
  input  logic [REGISTER_LENGTH-1:0] rf_rdata,
  input  logic [REGISTER_LENGTH-1:0] mem_rdata,
  input  logic                       mem_ack,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 rf_index,
  output logic                       rf_we,
  output logic [REGISTER_LENGTH-1:0] rf_wdata,
  output logic                       pc_we,
  output logic [REGISTER_LENGTH-1:0] pc_value,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [REGISTER_LENGTH-1:0] mem_addr,
  output logic [REGISTER_LENGTH-1:0] mem_wdata,
  output logic                       sp_we,
  output logic [REGISTER_LENGTH-1:0] new_sp,
  output state_e                     dbg_state,
  output bank_op_e                   dbg_bank_op
);

  localparam int MASK_W = LIST_WIDTH + 1;
  localparam int RL     = REGISTER_LENGTH;

  state_e              state_q;
  logic [MASK_W-1:0]   mask_q, mask_d, start_mask;
  logic                pop_q, pop_d, busy_q, done_q, sp_we_q, rf_we_q, pc_we_q;
  logic                mem_req_q, mem_we_q, enc_valid, cur_is_extra;
  logic [RL-1:0]       sp_final_q, data_q, new_sp_q, mem_addr_q, n_ext;
  logic [3:0]          rf_index_q, enc_idx, next_index, n_count;

  assign start_mask   = {extra_bit, reg_list};
  assign pop_d        = (state_q == S_IDLE) ? is_pop : pop_q;
  assign cur_is_extra = mask_q[MASK_W-1] && (mask_q[MASK_W-2:0] == '0);
  assign n_ext        = RL'(n_count);

  always_comb begin
    n_count = '0;
    for (int i = 0; i < MASK_W; i++) n_count = n_count + {3'b000, start_mask[i]};
  end

  // Mask as it will be after this edge; clearing the lowest set bit retires a transfer.
  always_comb begin
    mask_d = mask_q;
    case (state_q)
      S_IDLE:  mask_d = start_mask;
      S_XFER:  if (mem_ack) mask_d = mask_q & (mask_q - MASK_W'(1));
      default: mask_d = mask_q;
    endcase
  end

  reglist_priority_encoder #(.WIDTH(MASK_W), .IDX_W(4)) u_enc (
    .mask_i  (mask_d),
    .index_o (enc_idx),
    .valid_o (enc_valid)
  );

  assign next_index = (enc_idx == 4'(LIST_WIDTH)) ? (pop_d ? 4'(PC_INDEX) : 4'(LR_INDEX))
                                                  : enc_idx;

  // Memory handshake: mem_req is a valid that stays high, with mem_addr, mem_we and
  // rf_index frozen, until the cycle mem_ack is seen; mem_ack is the ready and is
  // ignored in every state except XFER.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      pop_q      <= 1'b0;
      sp_final_q <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sp_we_q    <= 1'b0;
      new_sp_q   <= '0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      rf_index_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q  <= 1'b0;
      sp_we_q <= 1'b0;
      rf_we_q <= 1'b0;
      pc_we_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q     <= 1'b1;
          pop_q      <= is_pop;
          mask_q     <= mask_d;
          sp_final_q <= is_pop ? sp_in + n_ext : sp_in - n_ext;
          if (enc_valid) begin
            state_q    <= S_XFER;
            mem_req_q  <= 1'b1;
            mem_we_q   <= !is_pop;
            mem_addr_q <= is_pop ? sp_in : sp_in - n_ext;
            rf_index_q <= next_index;
          end else begin
            state_q  <= S_FINISH;
            done_q   <= 1'b1;
            sp_we_q  <= 1'b1;
            new_sp_q <= sp_in;
          end
        end
        S_XFER: if (mem_ack) begin
          mask_q <= mask_d;
          if (pop_q) begin
            state_q   <= S_WB;
            mem_req_q <= 1'b0;
            data_q    <= mem_rdata;
            if (cur_is_extra) pc_we_q <= 1'b1;
            else              rf_we_q <= 1'b1;
          end else if (enc_valid) begin
            mem_addr_q <= mem_addr_q + RL'(1);
            rf_index_q <= next_index;
          end else begin
            state_q   <= S_FINISH;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            sp_we_q   <= 1'b1;
            new_sp_q  <= sp_final_q;
          end
        end
        S_WB: begin
          if (enc_valid) begin
            state_q    <= S_XFER;
            mem_req_q  <= 1'b1;
            mem_addr_q <= mem_addr_q + RL'(1);
            rf_index_q <= next_index;
          end else begin
            state_q  <= S_FINISH;
            done_q   <= 1'b1;
            sp_we_q  <= 1'b1;
            new_sp_q <= sp_final_q;
          end
        end
        S_FINISH: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          new_sp_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dbg_bank_op = BANK_NONE;
    if (pc_we_q)                 dbg_bank_op = BANK_PC;
    else if (rf_we_q)            dbg_bank_op = BANK_WRITE;
    else if (mem_req_q && !pop_q) dbg_bank_op = BANK_READ;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rf_index  = rf_index_q;
  assign rf_we     = rf_we_q;
  assign rf_wdata  = data_q;
  assign pc_we     = pc_we_q;
  assign pc_value  = data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = (mem_req_q && !pop_q) ? rf_rdata : '0;
  assign sp_we     = sp_we_q;
  assign new_sp    = new_sp_q;
  assign dbg_state = state_q;

endmodule
